// File: rtl/inv_shift_sub_unit.sv
// Iterative InvShiftRows + InvSubBytes stage for the AES-128 decryption datapath.
// InvShiftRows is folded into the capture; LANES shared inverse S-boxes then sweep the 16 bytes.

module inverseSbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[2047 - 8 * int'(in_byte) -: 8];
endmodule

module inv_shift_sub_unit #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int GROUPS = 16 / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $fatal(1, "inv_shift_sub_unit: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] grp;
    logic [3:0]    base;
    logic [7:0]    work    [16];
    logic [7:0]    shifted [16];
    logic [7:0]    sbox_out [LANES];

    assign base = 4'(int'(grp) * LANES);

    // Byte (r, c) of the working state comes from input column (c - r) mod 4.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            shifted[i] = in_data[127 - 8 * ((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)) -: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        inverseSbox u_sbox (
            .in_byte  (work[base + 4'(k)]),
            .out_byte (sbox_out[k])
        );
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = BUSY;
            BUSY:    if (grp == LAST_GRP) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The working register only changes at capture and while sweeping groups, so it
    // holds steady for the whole DONE phase regardless of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp <= '0;
            for (int i = 0; i < 16; i++) begin
                work[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        grp <= '0;
                        for (int i = 0; i < 16; i++) begin
                            work[i] <= shifted[i];
                        end
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES; k++) begin
                        work[base + 4'(k)] <= sbox_out[k];
                    end
                    grp <= (grp == LAST_GRP) ? '0 : grp + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 16; i++) begin
            out_data[127 - 8 * i -: 8] = work[i];
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Self-checking bench: five instances (LANES 4, 1, 2, 8, 16) against a reference built from
// GF(2^8) arithmetic, with a scoreboard queue of expected results.

module tb_inv_shift_sub_unit;
    localparam int NDUT = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NDUT-1:0]   in_valid;
    logic [NDUT-1:0]   out_ready;
    wire  [NDUT-1:0]   in_ready;
    wire  [NDUT-1:0]   out_valid;
    logic [127:0]      in_data  [NDUT];
    wire  [127:0]      out_data [NDUT];

    int                checks = 0;
    int                errors = 0;
    logic [7:0]        inv_sb [256];
    logic [127:0]      exp_q [$];
    int                cap_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        inv_shift_sub_unit #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    function automatic int lanes_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from inversion + affine map, then inverted into a lookup table.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            logic [7:0] s;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(x), 8'(c)) == 8'h01) b = 8'(c);
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            inv_sb[s] = 8'(x);
        end
    endtask

    // Row r is rotated right by r positions, then every byte goes through the inverse S-box.
    function automatic logic [127:0] ref_model(input logic [127:0] d);
        logic [7:0]   o [16];
        logic [127:0] res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r + 4 * ((c + r) % 4)] = inv_sb[d[127 - 8 * (r + 4 * c) -: 8]];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = o[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic capture_block(input logic [127:0] d);
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        exp_q.push_back(ref_model(d));
        @(negedge clk);
        in_valid[0] = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid[0] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                errors++; $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
            checks++;
            if (out_valid[i] !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            checks++;
            if (out_data[i] !== 128'h0) begin
                errors++; $display("[TB] FAIL reset_out_data[%0d]: got %h expected 0", i, out_data[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_zeros();
        int lat;
        logic [127:0] exp;
        capture_block(128'h0);
        wait_valid(lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL zeros_latency: got %0d expected 4", lat);
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_data[0] !== 128'h52525252525252525252525252525252) begin
            errors++; $display("[TB] FAIL zeros_const: got %h expected all 52", out_data[0]);
        end
        checks++;
        if (out_data[0] !== exp) begin
            errors++; $display("[TB] FAIL zeros_model: got %h expected %h", out_data[0], exp);
        end
        release_out();
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL zeros_handshake: got ready=%b valid=%b expected 1/0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_all_63();
        int lat;
        logic [127:0] exp;
        capture_block(128'h63636363636363636363636363636363);
        wait_valid(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL all63_latency: got %0d expected 4", lat);
        end
        checks++;
        if (out_data[0] !== 128'h0) begin
            errors++; $display("[TB] FAIL all63_const: got %h expected 0", out_data[0]);
        end
        checks++;
        if (out_data[0] !== exp) begin
            errors++; $display("[TB] FAIL all63_model: got %h expected %h", out_data[0], exp);
        end
        release_out();
    endtask

    task automatic test_byte_index();
        int lat;
        logic [127:0] exp;
        capture_block(128'h000102030405060708090a0b0c0d0e0f);
        wait_valid(lat);
        exp = exp_q.pop_front();
        checks++;
        if (out_data[0][127:96] !== 32'h52f3a338) begin
            errors++; $display("[TB] FAIL byteidx_col0: got %h expected 52f3a338", out_data[0][127:96]);
        end
        checks++;
        if (out_data[0] !== exp) begin
            errors++; $display("[TB] FAIL byteidx_model: got %h expected %h", out_data[0], exp);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] exp;
        logic [127:0] d = rand128();
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        exp_q.push_back(ref_model(d));
        @(negedge clk);
        in_data[0] = rand128();
        wait_valid(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== exp) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h expected 1/0/%h",
                         i, out_valid[0], in_ready[0], out_data[0], exp);
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== exp) begin
            errors++;
            $display("[TB] FAIL bp_release: got ready=%b valid=%b data=%h expected 1/0/%h",
                     in_ready[0], out_valid[0], out_data[0], exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] exp;
        capture_block(rand128());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== 128'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got valid=%b ready=%b data=%h expected 0/1/0",
                     out_valid[0], in_ready[0], out_data[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture_block(rand128());
        wait_valid(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL midreset_latency: got %0d expected 4", lat);
        end
        checks++;
        if (out_data[0] !== exp) begin
            errors++; $display("[TB] FAIL midreset_result: got %h expected %h", out_data[0], exp);
        end
        release_out();
    endtask

    // Streams blocks back to back with random downstream stalls; latency is measured
    // from the negedge that commits a capture to the first negedge showing out_valid.
    task automatic test_back_to_back(input int idx, input int nblocks);
        int  groups = 16 / lanes_of(idx);
        int  budget = nblocks * (groups + 2) * 4 + 100;
        int  sent = 0, recv = 0, cyc = 0;
        bit  captured_last = 1'b0;
        bit  prev_valid = 1'b0;
        logic [127:0] exp;
        exp_q.delete();
        cap_q.delete();
        in_data[idx]  = rand128();
        in_valid[idx] = 1'b1;
        while (recv < nblocks && cyc < budget) begin
            if (captured_last) begin
                in_data[idx]  = rand128();
                in_valid[idx] = (sent < nblocks);
            end
            out_ready[idx] = ($urandom_range(3) != 0);
            if (out_valid[idx] && !prev_valid) begin
                checks++;
                if (cap_q.size() == 0) begin
                    errors++; $display("[TB] FAIL stream%0d_spurious_valid: got valid with no block outstanding", idx);
                end else begin
                    int lat = cyc - cap_q.pop_front() - 1;
                    if (lat != groups) begin
                        errors++; $display("[TB] FAIL stream%0d_latency: got %0d expected %0d", idx, lat, groups);
                    end
                end
            end
            if (out_valid[idx] && out_ready[idx]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL stream%0d_extra_output: got %h with empty scoreboard", idx, out_data[idx]);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data[idx] !== exp) begin
                        errors++; $display("[TB] FAIL stream%0d_data[%0d]: got %h expected %h", idx, recv, out_data[idx], exp);
                    end
                end
                recv++;
            end
            captured_last = in_valid[idx] && in_ready[idx];
            if (captured_last) begin
                exp_q.push_back(ref_model(in_data[idx]));
                cap_q.push_back(cyc);
                sent++;
            end
            prev_valid = out_valid[idx];
            @(negedge clk);
            cyc++;
        end
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b0;
        checks++;
        if (recv != nblocks) begin
            errors++; $display("[TB] FAIL stream%0d_timeout: got %0d results expected %0d", idx, recv, nblocks);
        end
    endtask

    task automatic test_lane_sweep();
        for (int idx = 1; idx < NDUT; idx++) begin
            test_back_to_back(idx, 1000);
        end
    endtask

    initial begin
        build_tables();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < NDUT; i++) in_data[i] = '0;
        test_reset();
        test_all_zeros();
        test_all_63();
        test_byte_index();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(0, 50);
        test_lane_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
